dmemory_ws: RTL

- Parametrised successor to the 32k x 48 data memory: configurable word width, depth and address width, plus programmable wait states.
- Adds a busy/done handshake, so slower or larger memory technologies sit behind the same CPU-side interface.
- Keeps the BESM-6 convention that address 0 reads as zero.
- Sits between the CPU load/store unit and on-chip RAM; with WAIT=0 its timing matches the single-cycle data memory.

---
 rtl/dmemory_ws.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dmemory_ws.sv
// Parametrised data memory with programmable wait states and a busy/done handshake.
// Latency: o_done rises in the cycle after edge T0+WAIT (T0 = accept edge); WAIT=0 gives one access per cycle.
// Backpressure: o_busy is high while waiting; requests seen while busy are dropped, not queued.
// Optional even-parity protection per word is enabled by defining DMEM_PARITY_EN.
module dmemory_ws #(
  parameter int WIDTH      = 48,
  parameter int AW         = 15,
  parameter int DEPTH      = 32768,
  parameter int WAIT       = 0,
  parameter int ZERO_ADDR0 = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    i_addr,
  input  logic             i_read,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_done,
  output logic             o_busy
`ifdef DMEM_PARITY_EN
  ,
  output logic             o_perr,
  input  logic             i_perr_inject
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif
  localparam logic [3:0] WLOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAITING, DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             accept;
  logic             in_range;
  logic             zero_rd;
  logic [IW-1:0]    idx;
  logic [RW-1:0]    wdata;
  logic [RW-1:0]    mem [0:DEPTH-1];
  logic [RW-1:0]    rdata_q;
  logic             rd_q;
  logic             zero_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] hold;
`ifdef DMEM_PARITY_EN
  logic             perr_now;
  logic             perr_q;
`endif

  // Only WAITING blocks new requests; IDLE and DONE both accept.
  assign accept   = (i_read || i_write) && (state != WAITING);
  assign in_range = 32'(i_addr) < DEPTH;
  assign zero_rd  = !in_range || ((ZERO_ADDR0 != 0) && (i_addr == '0));
  assign idx      = i_addr[IW-1:0];

`ifdef DMEM_PARITY_EN
  // Even parity bit sits above the data; inject flips it to plant an error.
  assign wdata = {(^i_data) ^ i_perr_inject, i_data};
`else
  assign wdata = i_data;
`endif

  // Storage: write commits at the accept edge; read samples the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (accept && i_write && in_range) mem[idx] <= wdata;
    if (accept && i_read) rdata_q <= mem[idx];
  end

  // Value a completing read returns; forced-zero reads ignore whatever the RAM produced.
  assign hold = zero_q ? '0 : rdata_q[WIDTH-1:0];
`ifdef DMEM_PARITY_EN
  assign perr_now = rd_q && !zero_q && (^rdata_q);
`endif

  // State register, wait counter, access attributes and the held output word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rd_q   <= 1'b0;
      zero_q <= 1'b0;
      data_q <= '0;
`ifdef DMEM_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_q   <= i_read;
        zero_q <= zero_rd;
      end
      if (accept && (WAIT > 0)) cnt <= WLOAD;
      else if ((state == WAITING) && (cnt != 4'd0)) cnt <= cnt - 4'd1;
      if (state == DONE) begin
        if (rd_q) data_q <= hold;
`ifdef DMEM_PARITY_EN
        perr_q <= perr_now;
`endif
      end
    end
  end

  // Next-state logic: DONE behaves like IDLE so back-to-back accesses chain.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (WAIT == 0) ? DONE : WAITING;
        else        state_nxt = IDLE;
      end
      WAITING:      if (cnt == 4'd0) state_nxt = DONE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Outputs: the completing read's word is shown during DONE, then held in data_q.
  always_comb begin
    o_busy = (state == WAITING);
    o_done = (state == DONE);
    o_data = ((state == DONE) && rd_q) ? hold : data_q;
`ifdef DMEM_PARITY_EN
    o_perr = (state == DONE) ? perr_now : perr_q;
`endif
  end

endmodule
